mult_ram8_32bit: RTL and testbench

- 8-word × 32-bit synchronous register RAM plus a 32×32 unsigned multiplier.
- A small sequencer reads two RAM words, multiplies them, and writes the low 32 bits of the product back to a third RAM word.
- Used as the storage/compute core of the expression memory chip.
- External host can write and read RAM words directly, and can launch multiply commands.

---
 rtl/mult_ram8_32bit.sv | 103 ++++++++++
 tb/tb_mult_ram8_32bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mult_ram8_32bit.sv
// 8x32 register RAM with a host port and a read-multiply-writeback sequencer.
// Commands take four edges from the go sample to the product write.
module mult_ram8_32bit #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rw,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out0,
  input  logic             go,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WRITE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [WIDTH-1:0]   r_out0;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [AW-1:0]      r_src_a;
  logic [AW-1:0]      r_src_b;
  logic [AW-1:0]      r_dst;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_prod = (2*WIDTH)'(r_opa) * (2*WIDTH)'(r_opb);
  assign out    = w_prod[WIDTH-1:0];
  assign ovf    = |w_prod[2*WIDTH-1:WIDTH];
  assign out0   = r_out0;
  assign busy   = r_busy;
  assign done   = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (go) w_next = S_LOAD_A;
      S_LOAD_A: w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_WRITE;
      S_WRITE:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Host port and sequencer never write the RAM on the same edge: the host is
  // locked out whenever busy is set, which covers every non-IDLE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_out0  <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (en && !r_busy) begin
        if (rw) r_mem[address] <= in;
        else    r_out0 <= r_mem[address];
      end
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_src_a <= src_a;
            r_src_b <= src_b;
            r_dst   <= dst;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD_A: r_opa <= r_mem[r_src_a];
        S_LOAD_B: r_opb <= r_mem[r_src_b];
        S_WRITE: begin
          r_mem[r_dst] <= w_prod[WIDTH-1:0];
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_ram8_32bit.sv
// Directed bench for mult_ram8_32bit with a queue-based scoreboard of expected reads/products.
module tb_mult_ram8_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, rw, go;
  logic [2:0]  address, src_a, src_b, dst;
  logic [31:0] in;
  logic [31:0] out0, out;
  logic        ovf, busy, done;

  logic [31:0] m [8];
  logic [63:0] exp_q [$];
  int          n_pass = 0;
  int          n_total = 0;
  int          n_fail = 0;

  mult_ram8_32bit dut (
    .clk(clk), .reset(reset), .en(en), .rw(rw), .address(address), .in(in),
    .out0(out0), .go(go), .src_a(src_a), .src_b(src_b), .dst(dst),
    .out(out), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m[i] = 32'h0;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    en = 1'b1; rw = 1'b1; address = a; in = d;
    tick();
    en = 1'b0;
    m[a] = d;
  endtask

  task automatic host_read(input string tag, input logic [2:0] a);
    en = 1'b1; rw = 1'b0; address = a;
    exp_q.push_back({32'h0, m[a]});
    tick();
    en = 1'b0;
    check(tag, {32'h0, out0}, exp_q.pop_front());
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d);
    logic [63:0] p;
    logic [63:0] e;
    int          n;
    p = {32'h0, m[a]} * {32'h0, m[b]};
    exp_q.push_back(p);
    go = 1'b1; src_a = a; src_b = b; dst = d;
    tick();
    go = 1'b0;
    check({tag, "_busy_set"}, {63'h0, busy}, 64'd1);
    n = 0;
    while (!done && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_done_edges"}, 64'(n), 64'd3);
    check({tag, "_busy_clr"}, {63'h0, busy}, 64'd0);
    e = exp_q.pop_front();
    check({tag, "_out"}, {32'h0, out}, {32'h0, e[31:0]});
    check({tag, "_ovf"}, {63'h0, ovf}, {63'h0, |e[63:32]});
    m[d] = e[31:0];
    tick();
    check({tag, "_done_pulse"}, {63'h0, done}, 64'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; en = 1'b0; rw = 1'b0; go = 1'b0;
    address = '0; src_a = '0; src_b = '0; dst = '0; in = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out0", {32'h0, out0}, 64'h0);
    check("rst_out", {32'h0, out}, 64'h0);
    check("rst_ovf", {63'h0, ovf}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    reset = 1'b0;
    tick();

    // Asynchronous reset mid-cycle wipes RAM and read register.
    host_write(3'd5, 32'hDEADBEEF);
    host_read("rd5_before_rst", 3'd5);
    #2 reset = 1'b1;
    #1;
    check("arst_out0", {32'h0, out0}, 64'h0);
    check("arst_out", {32'h0, out}, 64'h0);
    check("arst_busy", {63'h0, busy}, 64'h0);
    check("arst_done", {63'h0, done}, 64'h0);
    #1 reset = 1'b0;
    clear_model();
    tick();
    host_read("rd5_after_rst", 3'd5);

    host_write(3'd0, 32'd6);
    host_write(3'd1, 32'd7);
    host_read("rd0", 3'd0);
    host_read("rd1", 3'd1);
    en = 1'b0;
    tick();
    check("out0_holds", {32'h0, out0}, 64'd7);

    run_cmd("mul42", 3'd0, 3'd1, 3'd2);
    host_read("rd2", 3'd2);

    host_write(3'd3, 32'h0001_0000);
    run_cmd("sq_ovf", 3'd3, 3'd3, 3'd4);
    host_read("rd4", 3'd4);

    host_write(3'd5, 32'hFFFF_FFFF);
    host_write(3'd6, 32'd2);
    run_cmd("ff_x2", 3'd5, 3'd6, 3'd7);
    host_read("rd7", 3'd7);

    // Busy lockout: host write and a second go during the command are dropped.
    exp_q.push_back({32'h0, m[0]} * {32'h0, m[1]});
    go = 1'b1; src_a = 3'd0; src_b = 3'd1; dst = 3'd3;
    tick();
    en = 1'b1; rw = 1'b1; address = 3'd6; in = 32'h55;
    src_a = 3'd5; src_b = 3'd5; dst = 3'd6;
    tick();
    tick();
    en = 1'b0; go = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ndone += int'(done);
    end
    check("lock_done_count", 64'(ndone), 64'd1);
    m[3] = exp_q[0][31:0];
    void'(exp_q.pop_front());
    host_read("lock_rd6", 3'd6);
    host_read("lock_rd3", 3'd3);

    // In-place: product overwrites operand A.
    host_write(3'd0, 32'd5);
    host_write(3'd1, 32'd3);
    run_cmd("inplace", 3'd0, 3'd1, 3'd0);
    host_read("rd0_inplace", 3'd0);

    // Reset while in LOAD_B: command aborts, no done, dst not written.
    go = 1'b1; src_a = 3'd0; src_b = 3'd1; dst = 3'd2;
    tick();
    go = 1'b0;
    tick();
    check("abort_busy_pre", {63'h0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_out", {32'h0, out}, 64'h0);
    #1 reset = 1'b0;
    clear_model();
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ndone += int'(done);
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    host_read("abort_rd2", 3'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
